hazard_ctrl: RTL and testbench

- Pipeline control block for the 5-stage core.
- Drives the active-low enable (en_n) and the synchronous clear of every stage register, plus the PC enable. Each stage register's clear input is the global reset ORed with that stage's flush output from this block.
- Resolves four hazard types: load-use stalls, taken-branch flushes, multicycle-unit (mul/div) waits and data-memory wait states.
- Sits beside the datapath. Inputs are decoded register indices and status flags from ID/EX/MEM. Outputs feed the stage registers in the same cycle.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_raw_cmp.sv | 14 +
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_e;

  localparam int STAGE_IF   = 0;
  localparam int STAGE_ID   = 1;
  localparam int STAGE_EX   = 2;
  localparam int STAGE_MEM  = 3;
  localparam int STAGE_WB   = 4;
  localparam int NUM_STAGES = 5;

  localparam int DEF_REG_ADDR_W  = 5;
  localparam int DEF_MC_TIMEOUT  = 64;
  localparam int DEF_STALL_CNT_W = 32;

endpackage

// File: rtl/hazard_raw_cmp.sv
// Single source-vs-destination RAW comparator; register 0 never matches.
module hazard_raw_cmp #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rd_write,
  output logic                  hit
);

  assign hit = rs_used & rd_write & (rd != '0) & (rs == rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hold/flush control for the 5-stage core (mem wait, mul/div wait, branch, RAW).
// HAZARD_FORWARDING_EN: when defined, only load-use in EX stalls; otherwise any EX/MEM producer stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MC_TIMEOUT  = DEF_MC_TIMEOUT,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_is_load,
  input  logic [REG_ADDR_W-1:0]  mem_rd,
  input  logic                   mem_reg_write,
  input  logic                   ex_branch_taken,
  input  logic                   ex_mc_start,
  input  logic                   mc_done,
  input  logic                   mem_access,
  input  logic                   dmem_ready,
  output logic                   pc_en_n,
  output logic                   ifid_en_n,
  output logic                   idex_en_n,
  output logic                   exmem_en_n,
  output logic                   memwb_en_n,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   memwb_flush,
  output logic                   mc_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MC_TIMEOUT - 1);

`ifdef HAZARD_FORWARDING_EN
  localparam int NUM_PROD = 1;
`else
  localparam int NUM_PROD = 2;
`endif

  hz_state_e state_reg, state_next;
  logic [CNT_W-1:0]       mc_cnt_reg, mc_cnt_next;
  logic [STALL_CNT_W-1:0] stall_count_reg;
  logic [NUM_STAGES-1:0]  en_n_vec;
  logic [STAGE_WB:STAGE_ID] flush_vec;

  logic [1:0][REG_ADDR_W-1:0]        rs_arr;
  logic [1:0]                        uses_arr;
  logic [NUM_PROD-1:0][REG_ADDR_W-1:0] rd_arr;
  logic [NUM_PROD-1:0]               wr_arr;
  logic [2*NUM_PROD-1:0]             hit_vec;
  logic                              unused_inputs;

  assign rs_arr   = {id_rs2, id_rs1};
  assign uses_arr = {id_uses_rs2, id_uses_rs1};

`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers ALU results; only a load in EX cannot be bypassed in time.
  assign rd_arr[0]     = ex_rd;
  assign wr_arr[0]     = ex_reg_write & ex_is_load;
  assign unused_inputs = ^{mem_rd, mem_reg_write};
`else
  assign rd_arr[0]     = ex_rd;
  assign wr_arr[0]     = ex_reg_write;
  assign rd_arr[1]     = mem_rd;
  assign wr_arr[1]     = mem_reg_write;
  assign unused_inputs = ex_is_load;
`endif

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      for (gj = 0; gj < NUM_PROD; gj++) begin : g_prod
        hazard_raw_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
          .rs       (rs_arr[gi]),
          .rs_used  (uses_arr[gi]),
          .rd       (rd_arr[gj]),
          .rd_write (wr_arr[gj]),
          .hit      (hit_vec[gi*NUM_PROD+gj])
        );
      end
    end
  endgenerate

  logic mem_stall;
  logic raw_stall;
  assign mem_stall = mem_access & ~dmem_ready;
  assign raw_stall = |hit_vec;

  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;
    en_n_vec    = '0;
    flush_vec   = '0;
    mc_timeout  = 1'b0;
    if (reset) begin
      flush_vec = '1;
    end else if (mem_stall) begin
      // Everything up to MEM freezes, including the FSM; WB gets a bubble.
      en_n_vec[STAGE_IF]  = 1'b1;
      en_n_vec[STAGE_ID]  = 1'b1;
      en_n_vec[STAGE_EX]  = 1'b1;
      en_n_vec[STAGE_MEM] = 1'b1;
      flush_vec[STAGE_WB] = 1'b1;
    end else if (state_reg == MC_WAIT) begin
      if (mc_done) begin
        state_next = RUN;
      end else if (mc_cnt_reg == TO_LAST) begin
        state_next = RUN;
        mc_timeout = 1'b1;
      end else begin
        en_n_vec[STAGE_IF]   = 1'b1;
        en_n_vec[STAGE_ID]   = 1'b1;
        en_n_vec[STAGE_EX]   = 1'b1;
        flush_vec[STAGE_MEM] = 1'b1;
        mc_cnt_next          = mc_cnt_reg + CNT_W'(1);
      end
    end else begin
      if (ex_mc_start) begin
        state_next  = MC_WAIT;
        mc_cnt_next = '0;
      end
      // A taken branch squashes the dependent instruction, so no RAW stall.
      if (ex_branch_taken) begin
        flush_vec[STAGE_ID] = 1'b1;
        flush_vec[STAGE_EX] = 1'b1;
      end else if (raw_stall) begin
        en_n_vec[STAGE_IF]  = 1'b1;
        en_n_vec[STAGE_ID]  = 1'b1;
        flush_vec[STAGE_EX] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      mc_cnt_reg      <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
      if (en_n_vec[STAGE_IF])
        stall_count_reg <= stall_count_reg + STALL_CNT_W'(1);
    end
  end

  assign pc_en_n     = en_n_vec[STAGE_IF];
  assign ifid_en_n   = en_n_vec[STAGE_ID];
  assign idex_en_n   = en_n_vec[STAGE_EX];
  assign exmem_en_n  = en_n_vec[STAGE_MEM];
  assign memwb_en_n  = en_n_vec[STAGE_WB];
  assign ifid_flush  = flush_vec[STAGE_ID];
  assign idex_flush  = flush_vec[STAGE_EX];
  assign exmem_flush = flush_vec[STAGE_MEM];
  assign memwb_flush = flush_vec[STAGE_WB];
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance uses MC_TIMEOUT=8 for the timeout path.
module tb_hazard_ctrl;

  // ctl = {pc,ifid,idex,exmem,memwb en_n, ifid,idex,exmem,memwb flush, mc_timeout}
  localparam logic [9:0] IDLE_V = 10'b00000_0000_0;
  localparam logic [9:0] RST_V  = 10'b00000_1111_0;
  localparam logic [9:0] RAW_V  = 10'b11000_0100_0;
  localparam logic [9:0] BR_V   = 10'b00000_1100_0;
  localparam logic [9:0] MC_V   = 10'b11100_0010_0;
  localparam logic [9:0] MEM_V  = 10'b11110_0001_0;
  localparam logic [9:0] TO_V   = 10'b00000_0000_1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic id_uses_rs1, id_uses_rs2, ex_reg_write, ex_is_load, mem_reg_write;
  logic ex_branch_taken, ex_mc_start, mc_done, mem_access, dmem_ready;
  logic [9:0] ctl, ctl8;
  logic [31:0] stall_count, stall_count8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en_n(ctl[9]), .ifid_en_n(ctl[8]), .idex_en_n(ctl[7]), .exmem_en_n(ctl[6]),
    .memwb_en_n(ctl[5]), .ifid_flush(ctl[4]), .idex_flush(ctl[3]), .exmem_flush(ctl[2]),
    .memwb_flush(ctl[1]), .mc_timeout(ctl[0]), .stall_count(stall_count)
  );

  hazard_ctrl #(.MC_TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en_n(ctl8[9]), .ifid_en_n(ctl8[8]), .idex_en_n(ctl8[7]), .exmem_en_n(ctl8[6]),
    .memwb_en_n(ctl8[5]), .ifid_flush(ctl8[4]), .idex_flush(ctl8[3]), .exmem_flush(ctl8[2]),
    .memwb_flush(ctl8[1]), .mc_timeout(ctl8[0]), .stall_count(stall_count8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_reg_write = 0; ex_is_load = 0; mem_rd = '0; mem_reg_write = 0;
    ex_branch_taken = 0; ex_mc_start = 0; mc_done = 0; mem_access = 0; dmem_ready = 1;
  endtask

  task automatic do_reset;
    clr_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset;
    clr_inputs();
    reset = 1;
    #2;
    checks++; if (ctl !== RST_V) begin errors++; $display("FAIL reset_out: ctl=%b expected %b", ctl, RST_V); end
    tick();
    reset = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL reset_idle: ctl=%b expected %b", ctl, IDLE_V); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_cnt: stall_count=%0d expected 0", stall_count); end
    tick();
  endtask

  task automatic test_load_use;
    logic [9:0] exp2;
    logic [31:0] expc;
`ifdef HAZARD_FORWARDING_EN
    exp2 = IDLE_V; expc = 32'd1;
`else
    exp2 = RAW_V; expc = 32'd2;
`endif
    do_reset();
    ex_rd = 5; ex_reg_write = 1; ex_is_load = 1; id_rs1 = 5; id_uses_rs1 = 1;
    #2;
    checks++; if (ctl !== RAW_V) begin errors++; $display("FAIL lu_stall: ctl=%b expected %b", ctl, RAW_V); end
    tick();
    ex_reg_write = 0; ex_is_load = 0; ex_rd = 0; mem_rd = 5; mem_reg_write = 1;
    #2;
    checks++; if (ctl !== exp2) begin errors++; $display("FAIL lu_after: ctl=%b expected %b", ctl, exp2); end
    tick();
    mem_reg_write = 0; mem_rd = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL lu_clear: ctl=%b expected %b", ctl, IDLE_V); end
    checks++; if (stall_count !== expc) begin errors++; $display("FAIL lu_cnt: stall_count=%0d expected %0d", stall_count, expc); end
    tick();
  endtask

  task automatic test_raw_boundaries;
    do_reset();
    ex_rd = 0; ex_reg_write = 1; ex_is_load = 1; id_rs1 = 0; id_uses_rs1 = 1;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL x0_nohaz: ctl=%b expected %b", ctl, IDLE_V); end
    tick();
    ex_rd = 9; id_rs1 = 3; id_rs2 = 9; id_uses_rs2 = 1;
    #2;
    checks++; if (ctl !== RAW_V) begin errors++; $display("FAIL rs2_stall: ctl=%b expected %b", ctl, RAW_V); end
    tick();
    id_uses_rs2 = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL rs2_unused: ctl=%b expected %b", ctl, IDLE_V); end
    tick();
    id_uses_rs2 = 1; ex_reg_write = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL no_write: ctl=%b expected %b", ctl, IDLE_V); end
    tick();
  endtask

  task automatic test_alu_raw;
    logic [9:0] exps;
    logic [31:0] expc;
`ifdef HAZARD_FORWARDING_EN
    exps = IDLE_V; expc = 32'd0;
`else
    exps = RAW_V; expc = 32'd2;
`endif
    do_reset();
    ex_rd = 7; ex_reg_write = 1; id_rs1 = 7; id_uses_rs1 = 1;
    #2;
    checks++; if (ctl !== exps) begin errors++; $display("FAIL alu_ex: ctl=%b expected %b", ctl, exps); end
    tick();
    ex_reg_write = 0; ex_rd = 0; mem_rd = 7; mem_reg_write = 1;
    #2;
    checks++; if (ctl !== exps) begin errors++; $display("FAIL alu_mem: ctl=%b expected %b", ctl, exps); end
    tick();
    mem_reg_write = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL alu_clear: ctl=%b expected %b", ctl, IDLE_V); end
    checks++; if (stall_count !== expc) begin errors++; $display("FAIL alu_cnt: stall_count=%0d expected %0d", stall_count, expc); end
    tick();
  endtask

  task automatic test_branch;
    do_reset();
    ex_branch_taken = 1; ex_rd = 5; ex_reg_write = 1; ex_is_load = 1; id_rs1 = 5; id_uses_rs1 = 1;
    #2;
    checks++; if (ctl !== BR_V) begin errors++; $display("FAIL br_over_lu: ctl=%b expected %b", ctl, BR_V); end
    tick();
    clr_inputs();
    #2;
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL br_cnt: stall_count=%0d expected 0", stall_count); end
    tick();
  endtask

  task automatic test_mc_wait;
    do_reset();
    ex_mc_start = 1;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL mc_start: ctl=%b expected %b", ctl, IDLE_V); end
    tick();
    ex_mc_start = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++; if (ctl !== MC_V) begin errors++; $display("FAIL mc_hold%0d: ctl=%b expected %b", i, ctl, MC_V); end
      tick();
    end
    mc_done = 1;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL mc_done: ctl=%b expected %b", ctl, IDLE_V); end
    tick();
    mc_done = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL mc_run: ctl=%b expected %b", ctl, IDLE_V); end
    checks++; if (stall_count !== 32'd10) begin errors++; $display("FAIL mc_cnt: stall_count=%0d expected 10", stall_count); end
    tick();
  endtask

  task automatic test_mc_timeout;
    do_reset();
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    for (int i = 0; i < 9; i++) begin
      mem_access = (i == 3 || i == 4);
      dmem_ready = !(i == 3 || i == 4);
      #2;
      if (i == 3 || i == 4) begin
        checks++; if (ctl8 !== MEM_V) begin errors++; $display("FAIL to_memfrz%0d: ctl=%b expected %b", i, ctl8, MEM_V); end
      end else begin
        checks++; if (ctl8 !== MC_V) begin errors++; $display("FAIL to_hold%0d: ctl=%b expected %b", i, ctl8, MC_V); end
      end
      tick();
    end
    mem_access = 0; dmem_ready = 1;
    #2;
    checks++; if (ctl8 !== TO_V) begin errors++; $display("FAIL to_pulse: ctl=%b expected %b", ctl8, TO_V); end
    tick();
    mc_done = 1;
    #2;
    checks++; if (ctl8 !== IDLE_V) begin errors++; $display("FAIL to_after: ctl=%b expected %b", ctl8, IDLE_V); end
    checks++; if (stall_count8 !== 32'd9) begin errors++; $display("FAIL to_cnt: stall_count=%0d expected 9", stall_count8); end
    tick();
    mc_done = 0;
    #2;
    checks++; if (ctl8 !== IDLE_V) begin errors++; $display("FAIL done_in_run: ctl=%b expected %b", ctl8, IDLE_V); end
    tick();
  endtask

  task automatic test_mem_stall_branch;
    do_reset();
    mem_access = 1; dmem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ctl !== MEM_V) begin errors++; $display("FAIL ms_hold%0d: ctl=%b expected %b", i, ctl, MEM_V); end
      tick();
    end
    dmem_ready = 1;
    #2;
    checks++; if (ctl !== BR_V) begin errors++; $display("FAIL ms_release: ctl=%b expected %b", ctl, BR_V); end
    tick();
    clr_inputs();
    #2;
    checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL ms_cnt: stall_count=%0d expected 3", stall_count); end
    tick();
  endtask

  task automatic test_mc_start_mem_stall;
    do_reset();
    mem_access = 1; dmem_ready = 0; ex_mc_start = 1;
    #2;
    checks++; if (ctl !== MEM_V) begin errors++; $display("FAIL defer_stall: ctl=%b expected %b", ctl, MEM_V); end
    tick();
    mem_access = 0; dmem_ready = 1; ex_mc_start = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL defer_noentry: ctl=%b expected %b", ctl, IDLE_V); end
    tick();
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    #2;
    checks++; if (ctl !== MC_V) begin errors++; $display("FAIL defer_entry: ctl=%b expected %b", ctl, MC_V); end
    tick();
    mem_access = 1; dmem_ready = 0;
    #2;
    checks++; if (ctl !== MEM_V) begin errors++; $display("FAIL mc_memprio: ctl=%b expected %b", ctl, MEM_V); end
    tick();
    mem_access = 0; dmem_ready = 1;
    #2;
    checks++; if (ctl !== MC_V) begin errors++; $display("FAIL mc_resume: ctl=%b expected %b", ctl, MC_V); end
    tick();
  endtask

  task automatic test_reset_mid_mc;
    do_reset();
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    repeat (3) tick();
    #2;
    checks++; if (ctl !== MC_V) begin errors++; $display("FAIL rm_inwait: ctl=%b expected %b", ctl, MC_V); end
    reset = 1;
    #1;
    checks++; if (ctl !== RST_V) begin errors++; $display("FAIL rm_reset: ctl=%b expected %b", ctl, RST_V); end
    tick();
    reset = 0;
    #2;
    checks++; if (ctl !== IDLE_V) begin errors++; $display("FAIL rm_run: ctl=%b expected %b", ctl, IDLE_V); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL rm_cnt: stall_count=%0d expected 0", stall_count); end
    tick();
  endtask

  initial begin
    clr_inputs();
    reset = 1;
    test_reset();
    test_load_use();
    test_raw_boundaries();
    test_alu_raw();
    test_branch();
    test_mc_wait();
    test_mc_timeout();
    test_mem_stall_branch();
    test_mc_start_mem_stall();
    test_reset_mid_mc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
